// File: rtl/seq_divider.sv
// Sequential signed divider: 16-bit dividend / 8-bit divisor, one quotient bit per clock.
// Restoring division runs on magnitudes; signs, saturation and divide-by-zero are resolved in FIX.
module seq_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder,
  output logic        busy,
  output logic        ready,
  output logic        overflow,
  output logic        div_zero
);

  typedef enum logic [1:0] {StIdle, StDiv, StFix} state_e;

  state_e      r_state, w_state_d;
  logic [3:0]  r_cnt, w_cnt_d;
  logic [7:0]  r_prem, w_prem_d;
  logic [15:0] r_qbits, w_qbits_d;
  logic [8:0]  r_dsr, w_dsr_d;
  logic        r_neg_n, w_neg_n_d;
  logic        r_neg_d, w_neg_d_d;
  logic        r_zero, w_zero_d;
  logic [7:0]  r_raw_lo, w_raw_lo_d;
  logic [7:0]  r_quot, w_quot_d;
  logic [7:0]  r_rem, w_rem_d;
  logic        r_ready, w_ready_d;
  logic        r_ovf, w_ovf_d;
  logic        r_dz, w_dz_d;

  logic [15:0] w_dvd_abs;
  logic [8:0]  w_dsr_ext;
  logic [8:0]  w_dsr_abs;
  logic [8:0]  w_shift;
  logic        w_ge;
  logic [7:0]  w_diff;
  logic        w_qneg;
  logic        w_qovf;
  logic [7:0]  w_qmag;

  assign w_dvd_abs = dividend[15] ? (~dividend + 16'd1) : dividend;
  assign w_dsr_ext = {divisor[7], divisor};
  assign w_dsr_abs = divisor[7] ? (~w_dsr_ext + 9'd1) : w_dsr_ext;

  // The dividend magnitude shifts out of r_qbits as quotient bits shift in.
  assign w_shift = {r_prem, r_qbits[15]};
  assign w_ge    = (w_shift >= r_dsr);
  // Difference is below |divisor| <= 128, so the low byte is exact.
  assign w_diff  = w_shift[7:0] - r_dsr[7:0];

  assign w_qneg = r_neg_n ^ r_neg_d;
  assign w_qovf = w_qneg ? (r_qbits > 16'd128) : (r_qbits > 16'd127);
  assign w_qmag = r_qbits[7:0];

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_prem_d   = r_prem;
    w_qbits_d  = r_qbits;
    w_dsr_d    = r_dsr;
    w_neg_n_d  = r_neg_n;
    w_neg_d_d  = r_neg_d;
    w_zero_d   = r_zero;
    w_raw_lo_d = r_raw_lo;
    w_quot_d   = r_quot;
    w_rem_d    = r_rem;
    w_ready_d  = r_ready;
    w_ovf_d    = r_ovf;
    w_dz_d     = r_dz;

    unique case (r_state)
      StIdle: begin
      end
      StDiv: begin
        w_prem_d  = w_ge ? w_diff : w_shift[7:0];
        w_qbits_d = {r_qbits[14:0], w_ge};
        w_cnt_d   = r_cnt + 4'd1;
        if (r_cnt == 4'd15) w_state_d = StFix;
      end
      StFix: begin
        w_state_d = StIdle;
        w_ready_d = 1'b1;
        if (r_zero) begin
          w_quot_d = 8'hFF;
          w_rem_d  = r_raw_lo;
          w_dz_d   = 1'b1;
          w_ovf_d  = 1'b0;
        end else begin
          w_dz_d  = 1'b0;
          w_ovf_d = w_qovf;
          if (w_qovf) w_quot_d = w_qneg ? 8'h80 : 8'h7F;
          else        w_quot_d = w_qneg ? (~w_qmag + 8'd1) : w_qmag;
          w_rem_d = r_neg_n ? (~r_prem + 8'd1) : r_prem;
        end
      end
      default: w_state_d = StIdle;
    endcase

    // A start edge wins in every state, aborting any division in flight.
    if (start) begin
      w_neg_n_d  = dividend[15];
      w_neg_d_d  = divisor[7];
      w_qbits_d  = w_dvd_abs;
      w_dsr_d    = w_dsr_abs;
      w_raw_lo_d = dividend[7:0];
      w_zero_d   = (divisor == 8'd0);
      w_prem_d   = 8'd0;
      w_cnt_d    = 4'd0;
      w_ready_d  = 1'b0;
      w_state_d  = (divisor == 8'd0) ? StFix : StDiv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_cnt    <= 4'd0;
      r_prem   <= 8'd0;
      r_qbits  <= 16'd0;
      r_dsr    <= 9'd0;
      r_neg_n  <= 1'b0;
      r_neg_d  <= 1'b0;
      r_zero   <= 1'b0;
      r_raw_lo <= 8'd0;
      r_quot   <= 8'd0;
      r_rem    <= 8'd0;
      r_ready  <= 1'b0;
      r_ovf    <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_prem   <= w_prem_d;
      r_qbits  <= w_qbits_d;
      r_dsr    <= w_dsr_d;
      r_neg_n  <= w_neg_n_d;
      r_neg_d  <= w_neg_d_d;
      r_zero   <= w_zero_d;
      r_raw_lo <= w_raw_lo_d;
      r_quot   <= w_quot_d;
      r_rem    <= w_rem_d;
      r_ready  <= w_ready_d;
      r_ovf    <= w_ovf_d;
      r_dz     <= w_dz_d;
    end
  end

  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign busy      = (r_state != StIdle);
  assign ready     = r_ready;
  assign overflow  = r_ovf;
  assign div_zero  = r_dz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, abort/reset sequences and
// randomized operands checked against an integer-arithmetic reference model.
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        ready;
  logic        overflow;
  logic        div_zero;

  int checks;
  int failures;

  seq_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .ready     (ready),
    .overflow  (overflow),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        ov;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: plain integer division truncates toward zero, % follows the dividend sign.
  function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic ov, output logic dz);
    int ia, ib, iq, ir;
    ia = $signed(a);
    ib = $signed(b);
    if (ib == 0) begin
      q = 8'hFF; r = a[7:0]; ov = 1'b0; dz = 1'b1;
    end else begin
      iq = ia / ib;
      ir = ia % ib;
      dz = 1'b0;
      ov = (iq > 127) || (iq < -128);
      if (ov) q = (iq > 0) ? 8'h7F : 8'h80;
      else    q = iq[7:0];
      r = ir[7:0];
    end
  endfunction

  // Issues one start and returns cycles until ready, or -1 if it never came.
  task automatic run_div(input logic [15:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("ready_after_start", int'(ready), 0);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (busy && ready) begin
        checks++; failures++;
        $display("FAIL busy_ready_exclusive actual=1 expected=0 cycle=%0d", n);
      end
      if (ready) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] q, input logic [7:0] r,
                              input logic ov, input logic dz);
    chk({tag, "_quotient"}, int'(quotient), int'(q));
    chk({tag, "_remainder"}, int'(remainder), int'(r));
    chk({tag, "_overflow"}, int'(overflow), int'(ov));
    chk({tag, "_div_zero"}, int'(div_zero), int'(dz));
    chk({tag, "_busy_clear"}, int'(busy), 0);
  endtask

  initial begin
    int lat;
    logic [7:0] mq, mr;
    logic mov, mdz;
    logic [15:0] ra;
    logic [7:0] rb;
    int bad;

    checks = 0;
    failures = 0;

    vecs[0] = '{16'd100,     8'd7,      8'd14,   8'd2,    1'b0, 1'b0, 17};
    vecs[1] = '{16'(-1000),  8'd9,      8'h91,   8'hFF,   1'b0, 1'b0, 17};
    vecs[2] = '{16'd1000,    8'(-9),    8'h91,   8'd1,    1'b0, 1'b0, 17};
    vecs[3] = '{16'(-1000),  8'(-9),    8'd111,  8'hFF,   1'b0, 1'b0, 17};
    vecs[4] = '{16'(-16384), 8'(-128),  8'h7F,   8'd0,    1'b1, 1'b0, 17};
    vecs[5] = '{16'd16256,   8'(-127),  8'h80,   8'd0,    1'b0, 1'b0, 17};
    vecs[6] = '{16'd1000,    8'd7,      8'h7F,   8'd6,    1'b1, 1'b0, 17};
    vecs[7] = '{16'h8000,    8'(-128),  8'h7F,   8'd0,    1'b1, 1'b0, 17};
    vecs[8] = '{16'h8000,    8'd127,    8'h80,   8'hFE,   1'b1, 1'b0, 17};
    vecs[9] = '{16'd500,     8'd0,      8'hFF,   8'hF4,   1'b0, 1'b1, 1};

    rst_n = 1'b0; start = 1'b0; dividend = 16'd0; divisor = 8'd0;
    #3;
    chk("reset_quotient", int'(quotient), 0);
    chk("reset_remainder", int'(remainder), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ready", int'(ready), 0);
    chk("reset_overflow", int'(overflow), 0);
    chk("reset_div_zero", int'(div_zero), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_ready", int'(ready), 0);
    chk("idle_no_busy", int'(busy), 0);

    foreach (vecs[i]) begin
      run_div(vecs[i].a, vecs[i].b, lat);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].ov, vecs[i].dz);
    end

    // Abort: second start 8 cycles after the first; no ready may appear in between.
    @(negedge clk);
    start = 1'b1; dividend = 16'd100; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    bad = 0;
    for (int n = 1; n <= 7; n++) begin
      @(posedge clk); #1;
      if (ready) bad++;
    end
    chk("abort_no_early_ready", bad, 0);
    run_div(16'd50, 8'd5, lat);
    chk("abort_latency", lat, 17);
    check_result("abort", 8'd10, 8'd0, 1'b0, 1'b0);

    // Start held high keeps restarting; ready must never rise.
    @(negedge clk);
    start = 1'b1; dividend = 16'd100; divisor = 8'd7;
    bad = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (ready || !busy) bad++;
    end
    chk("held_start_no_ready", bad, 0);
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ready) begin lat = n; break; end
    end
    chk("held_start_release_latency", lat, 17);
    check_result("held_start", 8'd14, 8'd2, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a division.
    run_div(16'h8000, 8'd127, lat);
    chk("pre_reset_overflow", int'(overflow), 1);
    @(negedge clk);
    start = 1'b1; dividend = 16'd1000; divisor = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_quotient", int'(quotient), 0);
    chk("midreset_remainder", int'(remainder), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_ready", int'(ready), 0);
    chk("midreset_overflow", int'(overflow), 0);
    chk("midreset_div_zero", int'(div_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk); #1;
      if (ready || busy) bad++;
    end
    chk("after_reset_quiet", bad, 0);

    // Randomized operands against the reference model.
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      if ($urandom_range(0, 1) == 1) ra = {{5{ra[10]}}, ra[10:0]};
      rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      model(ra, rb, mq, mr, mov, mdz);
      run_div(ra, rb, lat);
      chk($sformatf("rand%0d_latency a=%0d b=%0d", i, $signed(ra), $signed(rb)), lat,
          mdz ? 1 : 17);
      check_result($sformatf("rand%0d a=%0d b=%0d", i, $signed(ra), $signed(rb)),
                   mq, mr, mov, mdz);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
